oup_ulpi_regaccess: RTL
=======================

// Module: oup_ulpi_regaccess
// PURPOSE
//  Link-side ULPI register access engine. Turns a single-word req/ack register
//  request into a ULPI TX CMD register write or read on the ULPI pins, with
//  immediate and extended addressing. Sits between link control logic and the
//  ULPI PHY; the PHY model is its bus partner in simulation.
// PARAMETERS
//  NXT_TIMEOUT  64  cycles to wait for nxt (or read-turnaround dir) before err
// PORTS
//  clk_i        in   1  ULPI 60 MHz clock (PHY-sourced)
//  rst          in   1  reset: synchronous, active-high, sampled on clk_i
//  req_i        in   1  request strobe; sampled only in IDLE
//  we_i         in   1  1=write, 0=read
//  addr_i       in   8  register address
//  wdata_i      in   8  write data
//  busy_o       out  1  high from request accept until done_o
//  done_o       out  1  one-cycle pulse: transaction finished (ok or err)
//  err_o        out  1  valid with done_o: 1=aborted by PHY dir or timeout
//  rdata_o      out  8  read data; updated at done_o of a successful read
//  ulpi_data_o  out  8  link-driven data; 8'h00 (NOOP) when not in a command
//  ulpi_data_i  in   8  PHY-driven data
//  ulpi_dir_i   in   1  PHY owns bus when 1
//  ulpi_nxt_i   in   1  PHY throttle / accept
//  ulpi_stp_o   out  1  stop strobe ending a write
// BEHAVIOUR
//  Reset: state IDLE; busy_o,done_o,err_o,ulpi_stp_o=0; ulpi_data_o=8'h00;
//   rdata_o=8'h00; timeout counter cleared. rst mid-op drops bus immediately.
//  Addressing: addr<8'h40 and addr!=8'h2F -> immediate, TX CMD {op,addr[5:0]};
//   else extended: TX CMD {op,6'h2F} then addr byte. op=2'b10 write, 2'b11 read.
//  States/transitions (one registered FSM, outputs registered):
//   IDLE: req_i&~ulpi_dir_i -> latch we/addr/wdata, drive TX CMD, busy_o=1 ->
//     CMD. req_i while dir=1 is held off (not accepted) until dir=0.
//   CMD: hold TX CMD until nxt=1; then EXT (extended) else WDATA (write) or
//     RTURN (read). EXT: drive addr byte, hold until nxt=1, then WDATA/RTURN.
//   WDATA: drive wdata until nxt=1 -> STP.
//   STP: stp_o=1, data=8'h00 for exactly one cycle -> DONE(ok).
//   RTURN: data=8'h00; expect dir=1 (turnaround) -> RDATA.
//   RDATA: dir=1: capture ulpi_data_i into rdata_o -> RTURN2.
//   RTURN2: wait dir=0 -> DONE(ok).
//   DONE: done_o=1 one cycle, busy_o=0 at the same edge -> IDLE.
//  Abort: in CMD/EXT/WDATA, dir=1 before nxt seen -> stop driving (data=8'h00,
//   no stp), wait dir=0, then DONE(err). No automatic retry.
//  Timeout: counter resets on each state entry; reaching NXT_TIMEOUT in
//   CMD/EXT/WDATA/RTURN -> DONE(err). Counter width $clog2(NXT_TIMEOUT+1).
//  Latency, no throttle: write = CMD,WDATA,STP,DONE (+1 extended); nxt seen on
//   the first cycle of each phase advances next edge. Read adds 3 bus cycles.
//  dir=1 and nxt=1 together in CMD: treat as abort (RX CMD takes priority).
//  rdata_o retains last good value on error. Request inputs ignored while busy.
// STRUCTURE
//  Package oup_ulpi_pkg: TXCMD_REGW=2'b10, TXCMD_REGR=2'b11, EXT_ESC=6'h2F,
//   state enum regaccess_state_t, function is_extended(addr).
//  Single module; no sub-module (timeout counter inline).
// TESTING
//  Write SCRATCH 8'h16<=8'hA5, nxt each phase -> data 8'h96,8'hA5, stp 1 cyc.
//  Read 8'h16 after that -> data 8'hD6, dir turnaround, rdata_o=8'hA5, err=0.
//  Extended write addr 8'h80<=8'h3C -> data 8'hAF,8'h80,8'h3C then stp.
//  nxt held low 3 cycles in CMD -> TX CMD held stable 4 cycles, then proceeds.
//  dir rises in WDATA before nxt -> no stp, done_o with err_o=1; NXT_TIMEOUT=8
//   with nxt never asserted -> err_o=1 after 8 cycles in CMD.
//  rst asserted in RDATA -> next cycle IDLE, data 8'h00, busy_o=0, no done_o.

Source files
------------

// File: rtl/oup_ulpi_pkg.sv
// Shared constants, FSM state type and TX CMD helpers for the ULPI
// link-side register access engine.
package oup_ulpi_pkg;

  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;
  localparam logic [5:0] EXT_ESC    = 6'h2F;
  localparam logic [7:0] ULPI_NOOP  = 8'h00;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_CMD    = 4'd1,
    ST_EXT    = 4'd2,
    ST_WDATA  = 4'd3,
    ST_STP    = 4'd4,
    ST_RTURN  = 4'd5,
    ST_RDATA  = 4'd6,
    ST_RTURN2 = 4'd7,
    ST_ABORT  = 4'd8,
    ST_DONE   = 4'd9
  } regaccess_state_t;

  // Addresses that do not fit the 6-bit immediate field, plus the escape
  // code itself, need the extended (two-byte) addressing form.
  function automatic logic is_extended(input logic [7:0] addr);
    return (addr >= 8'h40) || (addr == {2'b00, EXT_ESC});
  endfunction

  // First byte the link puts on the bus for a register access.
  function automatic logic [7:0] tx_cmd(input logic we, input logic [7:0] addr);
    logic [1:0] op;
    op = we ? TXCMD_REGW : TXCMD_REGR;
    return is_extended(addr) ? {op, EXT_ESC} : {op, addr[5:0]};
  endfunction

endpackage

// File: rtl/oup_ulpi_regaccess.sv
// Link-side ULPI register access engine: turns a req/ack register request
// into a ULPI TX CMD register write or read, immediate or extended address.
// All outputs are registered; output values are derived from the next state.
module oup_ulpi_regaccess
  import oup_ulpi_pkg::*;
#(
  parameter int NXT_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic [7:0] ulpi_data_o,
  input  logic [7:0] ulpi_data_i,
  input  logic       ulpi_dir_i,
  input  logic       ulpi_nxt_i,
  output logic       ulpi_stp_o
);

  localparam int              CNT_W    = $clog2(NXT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NXT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  regaccess_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       cap_q, cap_d;
  logic             fail_s;
  logic             timeout_s;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       data_q, data_d;
  logic             stp_q, stp_d;

  assign timeout_s = (cnt_q == CNT_LAST);

  // State register, per-state cycle counter and latched request fields.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      cap_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state logic; dir has priority over nxt (an RX CMD pre-empts us).
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    fail_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i && !ulpi_dir_i) begin
          state_d = ST_CMD;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (ulpi_dir_i) begin
          state_d = ST_ABORT;
        end else if (ulpi_nxt_i) begin
          if (is_extended(addr_q)) begin
            state_d = ST_EXT;
          end else begin
            state_d = we_q ? ST_WDATA : ST_RTURN;
          end
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_EXT: begin
        if (ulpi_dir_i) begin
          state_d = ST_ABORT;
        end else if (ulpi_nxt_i) begin
          state_d = we_q ? ST_WDATA : ST_RTURN;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else begin
          state_d = ST_EXT;
        end
      end
      ST_WDATA: begin
        if (ulpi_dir_i) begin
          state_d = ST_ABORT;
        end else if (ulpi_nxt_i) begin
          state_d = ST_STP;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_STP: begin
        state_d = ST_DONE;
      end
      ST_RTURN: begin
        if (ulpi_dir_i) begin
          state_d = ST_RDATA;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else begin
          state_d = ST_RTURN;
        end
      end
      ST_RDATA: begin
        if (ulpi_dir_i) begin
          cap_d   = ulpi_data_i;
          state_d = ST_RTURN2;
        end else begin
          // PHY released the bus before delivering read data.
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end
      end
      ST_RTURN2: begin
        if (!ulpi_dir_i) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RTURN2;
        end
      end
      ST_ABORT: begin
        if (!ulpi_dir_i) begin
          state_d = ST_DONE;
          fail_s  = 1'b1;
        end else begin
          state_d = ST_ABORT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter restarts on every state entry and saturates while parked.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output decode from the next state so every pin is a flop output.
  always_comb begin
    data_d  = ULPI_NOOP;
    stp_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_d)
      ST_CMD: begin
        data_d = tx_cmd(we_d, addr_d);
        busy_d = 1'b1;
      end
      ST_EXT: begin
        data_d = addr_d;
        busy_d = 1'b1;
      end
      ST_WDATA: begin
        data_d = wdata_d;
        busy_d = 1'b1;
      end
      ST_STP: begin
        stp_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_RTURN, ST_RDATA, ST_RTURN2, ST_ABORT: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
        err_d  = fail_s;
        if (!fail_s && !we_q) begin
          rdata_d = cap_q;
        end else begin
          rdata_d = rdata_q;
        end
      end
      default: begin
        data_d = ULPI_NOOP;
      end
    endcase
  end

  // Output registers; reset drops the bus back to NOOP immediately.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      data_q  <= ULPI_NOOP;
      stp_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      data_q  <= data_d;
      stp_q   <= stp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ulpi_data_o = data_q;
  assign ulpi_stp_o  = stp_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;

endmodule
